// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM round-robin arbiter.
// Holds the FSM state encoding, the default RAM geometry and a helper that
// sizes requester-index fields.
package ram_ctrl_pkg;

   localparam int unsigned RAM_AW = 4;
   localparam int unsigned RAM_DW = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Width of a requester index; never zero, even for a single requester.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_rr_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the single-port RAM.
//   req/we/addr/wdata : packed per-requester commands (requester i at slice i)
//   ack/rdata/busy    : completion pulse, registered read data, activity flag
//   mem_*             : RAM address/data/strobes and RAM read data
// Modports: slave = the arbiter, master = requesters plus RAM side.
interface ram_rr_arbiter_if #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned AW      = ram_ctrl_pkg::RAM_AW,
   parameter int unsigned DW      = ram_ctrl_pkg::RAM_DW
);

   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    we;
   logic [NUM_REQ*AW-1:0] addr;
   logic [NUM_REQ*DW-1:0] wdata;
   logic [NUM_REQ-1:0]    ack;
   logic [DW-1:0]         rdata;
   logic                  busy;
   logic [AW-1:0]         mem_addr;
   logic [DW-1:0]         mem_wdata;
   logic                  mem_wr_en;
   logic                  mem_rd_en;
   logic [DW-1:0]         mem_rdata;

   modport slave (
      input  req, we, addr, wdata, mem_rdata,
      output ack, rdata, busy, mem_addr, mem_wdata, mem_wr_en, mem_rd_en
   );

   modport master (
      output req, we, addr, wdata, mem_rdata,
      input  ack, rdata, busy, mem_addr, mem_wdata, mem_wr_en, mem_rd_en
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   i_req     : pending request bits
//   i_ptr     : requester index that has highest priority this round
//   o_grant   : first set request found searching upward from i_ptr, wrapping
//   o_any_req : at least one request is pending
module rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IW      = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic [IW-1:0]      o_grant,
   output logic               o_any_req
);

   logic [IW-1:0] w_idx;

   always_comb begin
      o_grant   = '0;
      o_any_req = 1'b0;
      w_idx     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = IW'((i_ptr + k) % NUM_REQ);
         if (!o_any_req && i_req[w_idx]) begin
            o_grant   = w_idx;
            o_any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter and access sequencer in front of a single-port RAM.
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   io_bus : requester commands/acks and RAM port (slave side)
// Each transaction runs IDLE -> ACCESS -> RESP; the winner's command is latched
// in IDLE so later input changes cannot disturb an access in flight.
module ram_rr_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned AW      = RAM_AW,
   parameter int unsigned DW      = RAM_DW
) (
   input  logic                    clk,
   input  logic                    rst,
   ram_rr_arbiter_if.slave         io_bus
);

   localparam int unsigned IW   = idx_width(NUM_REQ);
   localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

   state_e              r_state;
   logic [IW-1:0]       r_rr_ptr;
   logic [IW-1:0]       r_cmd_id;
   logic                r_cmd_we;
   logic [AW-1:0]       r_cmd_addr;
   logic [DW-1:0]       r_cmd_wdata;
   logic [DW-1:0]       r_rdata;
   logic [NUM_REQ-1:0]  r_ack;

   logic [IW-1:0]       w_grant;
   logic                w_any_req;
   logic                w_sel_we;
   logic [AW-1:0]       w_sel_addr;
   logic [DW-1:0]       w_sel_wdata;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_pick (
      .i_req     (io_bus.req),
      .i_ptr     (r_rr_ptr),
      .o_grant   (w_grant),
      .o_any_req (w_any_req)
   );

   // Mux out the winning requester's command fields.
   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (w_grant == IW'(k)) begin
            w_sel_we    = io_bus.we[k];
            w_sel_addr  = io_bus.addr[k*AW +: AW];
            w_sel_wdata = io_bus.wdata[k*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_cmd_id    <= '0;
         r_cmd_we    <= 1'b0;
         r_cmd_addr  <= '0;
         r_cmd_wdata <= '0;
         r_rdata     <= '0;
         r_ack       <= '0;
      end else begin
         r_ack <= '0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_cmd_id    <= w_grant;
                  r_cmd_we    <= w_sel_we;
                  r_cmd_addr  <= w_sel_addr;
                  r_cmd_wdata <= w_sel_wdata;
                  r_state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (!r_cmd_we) begin
                  r_rdata <= io_bus.mem_rdata;
               end
               // Ack is registered so it is high exactly during RESP.
               r_ack   <= NUM_REQ'(1) << r_cmd_id;
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               r_rr_ptr <= (r_cmd_id == LAST) ? '0 : r_cmd_id + 1'b1;
               r_state  <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign io_bus.mem_addr  = r_cmd_addr;
   assign io_bus.mem_wdata = r_cmd_wdata;
   // Gating with rst keeps a write aborted by reset from landing in the RAM.
   assign io_bus.mem_wr_en = (r_state == ST_ACCESS) && r_cmd_we && !rst;
   assign io_bus.mem_rd_en = (r_state == ST_ACCESS) && !r_cmd_we;
   assign io_bus.ack       = r_ack;
   assign io_bus.rdata     = r_rdata;
   assign io_bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter: behavioural 16x16 RAM, a
// transaction-level reference model that orders requests round-robin, an
// expected-response queue and an independent ack monitor.
module tb_ram_rr_arbiter;

   localparam int N  = 2;
   localparam int AW = 4;
   localparam int DW = 16;
   localparam int FN = 6;  // fairness ops per requester

   typedef struct {
      int            id;
      bit            we;
      logic [DW-1:0] rdata;
   } exp_t;

   logic clk;
   logic rst;

   ram_rr_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

   ram_rr_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   // Behavioural RAM, preloaded with memory[i] = i.
   logic [DW-1:0] ram [16];
   bit            ram_loaded;
   int            wr_count;

   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 16; i++) ram[i] <= DW'(i);
         ram_loaded <= 1'b1;
      end else if (bus.mem_wr_en) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
         wr_count <= wr_count + 1;
      end
   end

   assign bus.mem_rdata = bus.mem_rd_en ? ram[bus.mem_addr] : '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks;
   int   errors;
   exp_t exp_q [$];

   // Reference model state.
   logic [DW-1:0] m_mem [16];
   int            m_ptr;

   logic          f_we   [N][FN];
   logic [AW-1:0] f_addr [N][FN];
   logic [DW-1:0] f_data [N][FN];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      bus.req   = '0;
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      m_ptr = 0;
   endtask

   // One round: the masked requesters raise req together while the DUT is idle
   // and each drops req once acked. With no new arrivals the service order is
   // simply cyclic from the round-robin pointer.
   task automatic run_round(input logic [N-1:0] mask, input logic [N-1:0] wes,
                            input logic [N*AW-1:0] addrs, input logic [N*DW-1:0] datas,
                            input bit poke_addr, output int first_ack);
      int            id;
      int            last;
      int            cyc;
      logic [N-1:0]  pend;
      logic [AW-1:0] a;
      exp_t          e;
      @(negedge clk);
      bus.req   = mask;
      bus.we    = wes;
      bus.addr  = addrs;
      bus.wdata = datas;
      last = -1;
      for (int k = 0; k < N; k++) begin
         id = (m_ptr + k) % N;
         if (mask[id]) begin
            a       = addrs[id*AW +: AW];
            e.id    = id;
            e.we    = wes[id];
            e.rdata = m_mem[a];
            if (wes[id]) m_mem[a] = datas[id*DW +: DW];
            exp_q.push_back(e);
            last = id;
         end
      end
      if (last >= 0) m_ptr = (last + 1) % N;
      pend      = mask;
      cyc       = 0;
      first_ack = -1;
      while (pend != '0 && cyc < 4 * N + 4) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            chk("busy_in_access", 32'(bus.busy), 32'd1);
            if (poke_addr) bus.addr[0 +: AW] = bus.addr[0 +: AW] ^ 4'hd;
         end
         for (int i = 0; i < N; i++) begin
            if (pend[i] && bus.ack[i]) begin
               pend[i]    = 1'b0;
               bus.req[i] = 1'b0;
               if (first_ack < 0) first_ack = cyc;
            end
         end
      end
      if (pend != '0) begin
         checks++;
         errors++;
         $display("FAIL round_timeout: pending %b after %0d cycles, expected none", pend, cyc);
      end
   endtask

   // Both requesters keep req high and reload a new command on each ack.
   task automatic fair_phase();
      int   id;
      int   cyc;
      int   done;
      int   last_ack;
      int   nxt [N];
      exp_t e;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < FN; k++) begin
            f_we[i][k]   = 1'($urandom_range(0, 1));
            f_addr[i][k] = AW'($urandom_range(0, 15));
            f_data[i][k] = DW'($urandom);
         end
      end
      for (int j = 0; j < N * FN; j++) begin
         id      = (m_ptr + j) % N;
         e.id    = id;
         e.we    = f_we[id][j / N];
         e.rdata = m_mem[f_addr[id][j / N]];
         if (e.we) m_mem[f_addr[id][j / N]] = f_data[id][j / N];
         exp_q.push_back(e);
      end
      m_ptr = (m_ptr + N * FN) % N;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         bus.req[i]             = 1'b1;
         bus.we[i]              = f_we[i][0];
         bus.addr[i*AW +: AW]   = f_addr[i][0];
         bus.wdata[i*DW +: DW]  = f_data[i][0];
         nxt[i]                 = 1;
      end
      done     = 0;
      cyc      = 0;
      last_ack = -1;
      while (done < N * FN && cyc < N * FN * 4 + 8) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < N; i++) begin
            if (bus.ack[i]) begin
               done++;
               if (last_ack >= 0) chk("ack_spacing", 32'(cyc - last_ack), 32'd3);
               last_ack = cyc;
               if (nxt[i] < FN) begin
                  bus.we[i]             = f_we[i][nxt[i]];
                  bus.addr[i*AW +: AW]  = f_addr[i][nxt[i]];
                  bus.wdata[i*DW +: DW] = f_data[i][nxt[i]];
                  nxt[i]++;
               end else begin
                  bus.req[i] = 1'b0;
               end
            end
         end
      end
      if (done < N * FN) begin
         checks++;
         errors++;
         $display("FAIL fair_timeout: %0d acks seen, expected %0d", done, N * FN);
      end
   endtask

   // Monitor: every ack pops one expected response.
   exp_t         mon_e;
   logic [N-1:0] mon_oh;
   initial begin
      forever begin
         @(negedge clk);
         if (bus.ack != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ack_unexpected: ack=%b, expected no ack", bus.ack);
            end else begin
               mon_e  = exp_q.pop_front();
               mon_oh = '0;
               mon_oh[mon_e.id] = 1'b1;
               if (bus.ack !== mon_oh) begin
                  errors++;
                  $display("FAIL ack_id: ack=%b, expected %b", bus.ack, mon_oh);
               end
               if (!mon_e.we) begin
                  checks++;
                  if (bus.rdata !== mon_e.rdata) begin
                     errors++;
                     $display("FAIL rdata: got %h, expected %h (requester %0d)",
                              bus.rdata, mon_e.rdata, mon_e.id);
                  end
               end
            end
         end
      end
   end

   int fa;
   int wr_before;

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = DW'(i);
      m_ptr     = 0;
      rst       = 1'b1;
      bus.req   = '0;
      bus.we    = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_ack", 32'(bus.ack), 32'd0);
      chk("reset_rdata", 32'(bus.rdata), 32'd0);
      chk("reset_wr_en", 32'(bus.mem_wr_en), 32'd0);
      chk("reset_rd_en", 32'(bus.mem_rd_en), 32'd0);

      // Single read of addr 5 by requester 0.
      wr_before = wr_count;
      run_round(2'b01, 2'b00, {4'd0, 4'd5}, '0, 1'b0, fa);
      chk("single_read_latency", 32'(fa), 32'd2);
      chk("single_read_no_write", 32'(wr_count - wr_before), 32'd0);

      // Requester 1 writes BEEF to addr 3, then reads it back.
      run_round(2'b10, 2'b10, {4'd3, 4'd0}, {16'hBEEF, 16'h0000}, 1'b0, fa);
      run_round(2'b10, 2'b00, {4'd3, 4'd0}, '0, 1'b0, fa);

      // Contention from reset, twice: R0 then R1 both times.
      do_reset();
      run_round(2'b11, 2'b00, {4'd2, 4'd1}, '0, 1'b0, fa);
      run_round(2'b11, 2'b00, {4'd2, 4'd1}, '0, 1'b0, fa);

      // Reset during the ACCESS cycle of a write must abort it.
      @(negedge clk);
      bus.req   = 2'b01;
      bus.we    = 2'b01;
      bus.addr  = {4'd0, 4'd7};
      bus.wdata = {16'h0000, 16'h1234};
      @(negedge clk);
      chk("abort_busy_access", 32'(bus.busy), 32'd1);
      rst     = 1'b1;
      bus.req = '0;
      @(negedge clk);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_ack", 32'(bus.ack), 32'd0);
      chk("abort_rdata", 32'(bus.rdata), 32'd0);
      rst   = 1'b0;
      m_ptr = 0;
      run_round(2'b01, 2'b00, {4'd0, 4'd7}, '0, 1'b0, fa);

      // Address change during ACCESS is ignored (4 -> 9).
      run_round(2'b01, 2'b00, {4'd0, 4'd4}, '0, 1'b1, fa);

      fair_phase();

      for (int r = 0; r < 40; r++) begin
         run_round(N'($urandom_range(1, (1 << N) - 1)), N'($urandom),
                   (N*AW)'($urandom), (N*DW)'({$urandom, $urandom}), 1'b0, fa);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
Round-robin arbiter and access sequencer for the 16-word x 16-bit single-port RAM. It lets NUM_REQ independent requesters share the RAM's single address/data port. For each granted request it drives the RAM's clk-domain write strobe and combinational read strobe, captures read data into a register, and returns a one-cycle ack to the winning requester. It sits between the requester blocks and the RAM instance.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
AW, 4, RAM address width
DW, 16, RAM data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request; held high until its ack
we  input  NUM_REQ  per-requester op: 1 = write, 0 = read; valid while req is high
addr  input  NUM_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
wdata  input  NUM_REQ*DW  packed write data; requester i uses bits [i*DW +: DW]
ack  output  NUM_REQ  one-hot, one-cycle completion pulse
rdata  output  DW  registered read data; valid in the ack cycle of a read
busy  output  1  high whenever state != IDLE
mem_addr  output  AW  to RAM address
mem_wdata  output  DW  to RAM data_in
mem_wr_en  output  1  to RAM wr_en
mem_rd_en  output  1  to RAM rd_en
mem_rdata  input  DW  from RAM data_out

Behaviour:
- Reset values: state = IDLE; ack = 0; rdata = 0; busy = 0; rr_ptr = 0; latched cmd_id/cmd_we/cmd_addr/cmd_wdata = 0.
- FSM states: IDLE, ACCESS, RESP. Each state lasts one cycle except IDLE.
- IDLE, no req: stay in IDLE.
- IDLE, any req: select a winner by searching from rr_ptr upward with wrap to 0. The first set req bit wins. Latch cmd_id, we, addr and wdata for the winner, then go to ACCESS.
- ACCESS:
  - mem_addr = cmd_addr and mem_wdata = cmd_wdata.
  - mem_wr_en = cmd_we & ~rst, so the RAM write lands on the edge ending ACCESS.
  - mem_rd_en = ~cmd_we. rdata <= mem_rdata on the edge ending ACCESS, for reads only; writes leave rdata unchanged.
  - Go to RESP.
- RESP: ack[cmd_id] = 1 and all other ack bits = 0. rr_ptr <= (cmd_id + 1) mod NUM_REQ. Go to IDLE.
- Outside ACCESS: mem_wr_en = 0 and mem_rd_en = 0. mem_addr and mem_wdata hold the latched cmd values.
- Latency: req first seen high at edge E0 gives ACCESS in cycle E0..E1 and ack high in cycle E1..E2. Throughput is one access per 3 cycles under continuous load.
- Handshake: the requester holds req, we, addr and wdata stable until it sees ack. It deasserts req on the edge ending the ack cycle. A req still high in the following IDLE is treated as a new request.
- Inputs are sampled only in IDLE. Changes to req, we, addr or wdata during ACCESS or RESP are ignored.
- Simultaneous requests: exactly one winner per round-robin. Losers stay pending and no request is lost. With all NUM_REQ requesters continuously active, each is served once every NUM_REQ transactions.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-operation: when rst is high at any edge, the FSM returns to IDLE and all outputs take their reset values. A write whose ACCESS cycle coincides with rst is suppressed (mem_wr_en gated by ~rst). No ack is issued for an aborted transaction.
- Address arithmetic: AW-bit addresses, no bounds check; all 16 addresses are legal.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - state enum/localparams ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2;
  - default widths AW = 4, DW = 16.
- One sub-module, rr_pick: purely combinational. Inputs are req and rr_ptr; outputs are a grant index and an any_req flag.
- FSM and datapath latches stay in the top module.

Test Plan:
- Single read: after reset (RAM preloaded with memory[i] = i), requester 0 reads addr 5 -> ack[0] high 2 cycles after req is sampled, rdata = 16'h0005, mem_wr_en never high.
- Write then read: requester 1 writes 16'hBEEF to addr 3, then reads addr 3 -> ack[1] pulses twice and the second ack has rdata = 16'hBEEF.
- Contention: req = 2'b11 from reset (rr_ptr = 0), R0 reads addr 1, R1 reads addr 2 -> ack[0] first with rdata = 1, then ack[1] with rdata = 2. The next simultaneous pair is served R0 then R1 again (pointer wrap).
- Fairness: both requesters hold req continuously for 12 transactions -> grants alternate strictly 0,1,0,1…; each ack is one cycle wide; never two ack bits high at once.
- Reset mid-write: R0 writes 16'h1234 to addr 7, rst asserted during the ACCESS cycle -> no ack, busy = 0 next cycle; a subsequent read of addr 7 returns 16'h0007.
- Ignored changes: R0 changes addr from 4 to 9 during ACCESS -> the read still returns 16'h0004.
